request_issuer: RTL

// - Transmit side of the ack-based request handshake used by fifo_queue input ports.
// - Accepts entries from an upstream ready/valid source into a 2-entry in-order staging buffer.
// - Presents the oldest entry downstream and holds it stable until the receiver's one-cycle

---
 rtl/request_issuer_if.sv | 26 ++
 rtl/request_issuer.sv | 102 ++++++++++
 2 files changed

// File: rtl/request_issuer_if.sv
// rtl/request_issuer_if.sv - upstream push, downstream issue/ack and status signals of request_issuer
interface request_issuer_if #(
   parameter int WIDTH = 512
);
   logic [WIDTH-1:0] request_in;
   logic             request_valid_in;
   logic             request_ready_out;
   logic [WIDTH-1:0] request_out;
   logic             request_valid_out;
   logic             issue_ack_in;
   logic [1:0]       pending_count_out;
   logic             stall_timeout_out;
   logic             protocol_error_out;

   modport slave (
      input  request_in, request_valid_in, issue_ack_in,
      output request_ready_out, request_out, request_valid_out,
             pending_count_out, stall_timeout_out, protocol_error_out
   );

   modport master (
      output request_in, request_valid_in, issue_ack_in,
      input  request_ready_out, request_out, request_valid_out,
             pending_count_out, stall_timeout_out, protocol_error_out
   );
endinterface

// File: rtl/request_issuer.sv
// rtl/request_issuer.sv - 2-entry in-order staging buffer issuing entries under a one-cycle ack handshake
module request_issuer #(
   parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 512,
   parameter int STALL_CNT_WIDTH_IN_BITS    = 8,
   parameter int STALL_THRESHOLD            = 200
) (
   input  logic            clk_in,
   input  logic            reset_in,
   request_issuer_if.slave bus
);
   localparam int W  = SINGLE_ENTRY_WIDTH_IN_BITS;
   localparam int CW = STALL_CNT_WIDTH_IN_BITS;
   localparam logic [CW-1:0] STALL_TH = CW'(STALL_THRESHOLD);

   typedef enum logic {IDLE, ISSUE} state_t;
   state_t state, state_next;

   logic [W-1:0]  slot_mem [2];
   logic          rd_ptr, wr_ptr;
   logic [1:0]    count, count_next, left_after_pop;
   logic          push, pop;
   logic [W-1:0]  head_next;
   logic [W-1:0]  request_q;
   logic [CW-1:0] stall_cnt, stall_cnt_next;
   logic          stall_timeout, protocol_error;

   assign push           = bus.request_valid_in & (count != 2'd2);
   assign pop            = bus.issue_ack_in & (state == ISSUE);
   assign count_next     = count + {1'b0, push} - {1'b0, pop};
   assign left_after_pop = count - {1'b0, pop};

   // With storage empty after the pop, the next head is the entry arriving on this same edge.
   always_comb begin
      head_next = slot_mem[rd_ptr ^ pop];
      if (left_after_pop == 2'd0)
         head_next = bus.request_in;
   end

   always_comb begin
      stall_cnt_next = stall_cnt;
      if (state == IDLE || pop)
         stall_cnt_next = '0;
      else if (stall_cnt != '1)
         stall_cnt_next = stall_cnt + 1'b1;
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (count_next != 2'd0) state_next = ISSUE;
         ISSUE:   if (pop && count_next == 2'd0) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.request_valid_out = (state == ISSUE);
   end

   always_ff @(posedge clk_in) begin
      if (push)
         slot_mem[wr_ptr] <= bus.request_in;
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         count          <= 2'd0;
         rd_ptr         <= 1'b0;
         wr_ptr         <= 1'b0;
         request_q      <= '0;
         stall_cnt      <= '0;
         stall_timeout  <= 1'b0;
         protocol_error <= 1'b0;
      end else begin
         count <= count_next;
         if (push)
            wr_ptr <= ~wr_ptr;
         if (pop)
            rd_ptr <= ~rd_ptr;
         if (state_next == ISSUE && (state == IDLE || pop))
            request_q <= head_next;
         else if (state_next == IDLE)
            request_q <= '0;
         stall_cnt      <= stall_cnt_next;
         stall_timeout  <= (stall_cnt_next >= STALL_TH) && (state_next == ISSUE);
         protocol_error <= protocol_error | (bus.issue_ack_in & (state != ISSUE));
      end
   end

   assign bus.request_ready_out  = (count != 2'd2);
   assign bus.pending_count_out  = count;
   assign bus.request_out        = request_q;
   assign bus.stall_timeout_out  = stall_timeout;
   assign bus.protocol_error_out = protocol_error;
endmodule
